// File: rtl/fft_bfly_stage_ctrl.sv
// -----------------------------------------------------------------------------
// fft_bfly_stage_ctrl
// Frame sequencer for one radix-2 delay-feedback butterfly stage. Counts input
// beats of a COUNT-beat frame and drives the stage controls: butterfly enable,
// twiddle ROM address, output mux select, output valid and frame status.
//
// Ports
//   clk         stage clock
//   rstn        asynchronous active-low reset
//   valid_in    input beat present (COUNT consecutive cycles per frame)
//   bfly_en     comb: high while beats HALF..COUNT-1 are accepted
//   out_sel     reg : 0 = butterfly sums, 1 = delayed differences (drain)
//   twd_addr    comb: beat-HALF while bfly_en, else 0
//   out_valid   reg : output beat valid on datapath output registers
//   beat_cnt    index of the input beat presented this cycle
//   frame_done  reg : pulse on the last output beat of a frame
//   err_gap     reg : pulse after valid_in dropped mid-frame
//   busy        frame in progress, drain running or output still valid
//   frame_cnt   completed frames, wraps modulo 2^FCNT_W
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no frame in progress; valid_in here is beat 0 of a new frame
// FILL  | beats 1..HALF-1, delay line filling, butterfly idle
// CALC  | beats HALF..COUNT-1, butterfly active, sums leave next cycle
// -----------------------------------------------------------------------------
module fft_bfly_stage_ctrl #(
   parameter  int NUM    = 16,
   parameter  int DATA   = 512,
   parameter  int FCNT_W = 8,
   localparam int COUNT  = DATA / NUM,
   localparam int HALF   = COUNT / 2,
   localparam int BW     = $clog2(COUNT),
   localparam int TW     = $clog2(HALF)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              valid_in,
   output logic              bfly_en,
   output logic              out_sel,
   output logic [TW-1:0]     twd_addr,
   output logic              out_valid,
   output logic [BW-1:0]     beat_cnt,
   output logic              frame_done,
   output logic              err_gap,
   output logic              busy,
   output logic [FCNT_W-1:0] frame_cnt
);

   localparam int DW = $clog2(HALF + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_CALC = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic [DW-1:0]   drain_q, drain_d;
   logic            last_beat;
   logic            gap;
   logic            drain_act;
   logic            drain_last;
   logic            out_valid_d;

   assign drain_act  = (drain_q != '0);
   assign drain_last = (drain_q == DW'(1));

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      last_beat = 1'b0;
      gap       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (valid_in) begin
               beat_d  = BW'(1);
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            if (valid_in) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == BW'(HALF - 1)) state_d = S_CALC;
            end else begin
               gap     = (beat_q != '0);
               beat_d  = '0;
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            if (valid_in) begin
               // beat_q + 1 wraps COUNT-1 -> 0 because COUNT is a power of two
               beat_d = beat_q + 1'b1;
               if (beat_q == BW'(COUNT - 1)) begin
                  last_beat = 1'b1;
                  // back-to-back frames re-enter through IDLE, which accepts beat 0
                  state_d   = S_IDLE;
               end
            end else begin
               gap     = (beat_q != '0);
               beat_d  = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            beat_d  = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Drain runs on its own so it can overlap the next frame's FILL phase.
   always_comb begin
      drain_d = drain_q;
      if (last_beat) drain_d = DW'(HALF);
      else if (drain_act) drain_d = drain_q - 1'b1;
   end

   // Low-phase sums leave one cycle after each CALC beat; drain beats follow.
   assign out_valid_d = ((state_q == S_CALC) && valid_in) || drain_act;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         beat_q     <= '0;
         drain_q    <= '0;
         out_valid  <= 1'b0;
         out_sel    <= 1'b0;
         frame_done <= 1'b0;
         err_gap    <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         drain_q    <= drain_d;
         out_valid  <= out_valid_d;
         out_sel    <= drain_act;
         frame_done <= drain_last;
         err_gap    <= gap;
         if (drain_last) frame_cnt <= frame_cnt + 1'b1;
      end
   end

   assign beat_cnt = beat_q;
   assign bfly_en  = (state_q == S_CALC) && valid_in;
   // In CALC beat_q is HALF..COUNT-1, so its low bits are beat-HALF.
   assign twd_addr = bfly_en ? beat_q[TW-1:0] : '0;
   assign busy     = (state_q != S_IDLE) || drain_act || out_valid;

endmodule

// File: tb/tb_fft_bfly_stage_ctrl.sv
module tb_fft_bfly_stage_ctrl;

   localparam int NUM    = 16;
   localparam int DATA   = 512;
   localparam int FCNT_W = 8;
   localparam int COUNT  = DATA / NUM;
   localparam int HALF   = COUNT / 2;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              valid_in = 1'b0;
   logic              bfly_en;
   logic              out_sel;
   logic [3:0]        twd_addr;
   logic              out_valid;
   logic [4:0]        beat_cnt;
   logic              frame_done;
   logic              err_gap;
   logic              busy;
   logic [FCNT_W-1:0] frame_cnt;

   fft_bfly_stage_ctrl #(.NUM(NUM), .DATA(DATA), .FCNT_W(FCNT_W)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .valid_in   (valid_in),
      .bfly_en    (bfly_en),
      .out_sel    (out_sel),
      .twd_addr   (twd_addr),
      .out_valid  (out_valid),
      .beat_cnt   (beat_cnt),
      .frame_done (frame_done),
      .err_gap    (err_gap),
      .busy       (busy),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int   cyc;
      logic sel;
      logic done;
   } exp_t;

   exp_t              oq[$];
   int                gq[$];
   int                total = 0;
   int                bad = 0;
   logic [FCNT_W-1:0] exp_fc = '0;
   bit                mon_en = 1'b0;

   // Scoreboard: expected output beats and err_gap pulses, checked each cycle.
   always @(negedge clk) begin : monitor
      logic exp_v;
      logic exp_g;
      exp_t e;
      if (mon_en) begin
         while (oq.size() > 0 && oq[0].cyc < cyc) begin
            total++; bad++;
            $display("FAIL out_missing: expected output beat at cycle %0d not seen", oq[0].cyc);
            void'(oq.pop_front());
         end
         while (gq.size() > 0 && gq[0] < cyc) begin
            total++; bad++;
            $display("FAIL gap_missing: expected err_gap at cycle %0d not seen", gq[0]);
            void'(gq.pop_front());
         end
         exp_v = (oq.size() > 0) && (oq[0].cyc == cyc);
         total++;
         if (out_valid !== exp_v) begin
            bad++;
            $display("FAIL out_valid cyc=%0d got=%b want=%b", cyc, out_valid, exp_v);
         end
         if (exp_v) begin
            e = oq.pop_front();
            total++;
            if (out_sel !== e.sel) begin
               bad++;
               $display("FAIL out_sel cyc=%0d got=%b want=%b", cyc, out_sel, e.sel);
            end
            total++;
            if (frame_done !== e.done) begin
               bad++;
               $display("FAIL frame_done cyc=%0d got=%b want=%b", cyc, frame_done, e.done);
            end
            total++;
            if (busy !== 1'b1) begin
               bad++;
               $display("FAIL busy_with_valid cyc=%0d got=%b want=1", cyc, busy);
            end
            if (e.done) exp_fc = exp_fc + 1'b1;
         end else begin
            total++;
            if (frame_done !== 1'b0) begin
               bad++;
               $display("FAIL frame_done_idle cyc=%0d got=%b want=0", cyc, frame_done);
            end
         end
         total++;
         if (frame_cnt !== exp_fc) begin
            bad++;
            $display("FAIL frame_cnt cyc=%0d got=%0d want=%0d", cyc, frame_cnt, exp_fc);
         end
         exp_g = (gq.size() > 0) && (gq[0] == cyc);
         if (exp_g) void'(gq.pop_front());
         total++;
         if (err_gap !== exp_g) begin
            bad++;
            $display("FAIL err_gap cyc=%0d got=%b want=%b", cyc, err_gap, exp_g);
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives nbeats consecutive valid beats (frames back-to-back) then drops
   // valid_in; pushes the expected output beats and any err_gap pulse.
   task automatic drive(input int nbeats, output int t_first);
      int i;
      int t0;
      logic [3:0] et;
      t_first = -1;
      t0 = 0;
      for (int b = 0; b < nbeats; b++) begin
         @(posedge clk); #1;
         valid_in = 1'b1;
         i = b % COUNT;
         if (i == 0) t0 = cyc;
         if (b == 0) t_first = cyc;
         #1;
         total++;
         if (beat_cnt !== 5'(i)) begin
            bad++;
            $display("FAIL beat_cnt cyc=%0d got=%0d want=%0d", cyc, beat_cnt, i);
         end
         total++;
         if (bfly_en !== (i >= HALF)) begin
            bad++;
            $display("FAIL bfly_en cyc=%0d beat=%0d got=%b want=%b", cyc, i, bfly_en, (i >= HALF));
         end
         et = (i >= HALF) ? 4'(i - HALF) : 4'd0;
         total++;
         if (twd_addr !== et) begin
            bad++;
            $display("FAIL twd_addr cyc=%0d beat=%0d got=%0d want=%0d", cyc, i, twd_addr, et);
         end
         if (i >= HALF) oq.push_back('{t0 + i + 1, 1'b0, 1'b0});
         if (i == COUNT - 1)
            for (int j = 1; j <= HALF; j++)
               oq.push_back('{t0 + COUNT + j, 1'b1, (j == HALF)});
      end
      @(posedge clk); #1;
      valid_in = 1'b0;
      if (nbeats % COUNT != 0) gq.push_back(cyc + 1);
   endtask

   task automatic check_drained(input string name);
      total++;
      if (oq.size() != 0 || gq.size() != 0) begin
         bad++;
         $display("FAIL %s_drained pending_out=%0d pending_gap=%0d want=0", name, oq.size(), gq.size());
      end
   endtask

   task automatic check_fc(input string name, input logic [FCNT_W-1:0] want);
      total++;
      if (frame_cnt !== want) begin
         bad++;
         $display("FAIL %s_frame_cnt got=%0d want=%0d", name, frame_cnt, want);
      end
   endtask

   // Asserts rstn away from any clock edge and checks outputs clear at once.
   task automatic do_reset(input string name);
      @(posedge clk); #3;
      mon_en = 1'b0;
      rstn = 1'b0;
      #1;
      total++;
      if ({out_valid, out_sel, frame_done, err_gap, busy, bfly_en} !== 6'b0) begin
         bad++;
         $display("FAIL %s_rst_flags got=%b want=000000", name,
                  {out_valid, out_sel, frame_done, err_gap, busy, bfly_en});
      end
      total++;
      if (beat_cnt !== 5'd0 || twd_addr !== 4'd0 || frame_cnt !== '0) begin
         bad++;
         $display("FAIL %s_rst_counts beat=%0d twd=%0d fcnt=%0d want=0", name, beat_cnt, twd_addr, frame_cnt);
      end
      oq.delete();
      gq.delete();
      exp_fc = '0;
      @(posedge clk); #3;
      rstn = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic test_reset();
      do_reset("reset");
      wait_cycles(4);
      check_fc("reset", 8'd0);
   endtask

   task automatic test_single_frame();
      int t;
      do_reset("single");
      drive(COUNT, t);
      wait_cycles(COUNT + HALF + 4);
      check_drained("single");
      check_fc("single", 8'd1);
   endtask

   task automatic test_back_to_back();
      int t;
      do_reset("b2b");
      drive(3 * COUNT, t);
      while (cyc < t + 3 * COUNT + HALF) begin
         @(posedge clk); #1;
      end
      #1;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL b2b_busy_last got=%b want=1", busy);
      end
      @(posedge clk); #2;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_busy_drop got=%b want=0", busy);
      end
      wait_cycles(4);
      check_drained("b2b");
      check_fc("b2b", 8'd3);
   endtask

   task automatic test_gap_fill_drain();
      int t;
      do_reset("gapfill");
      drive(COUNT + 10, t);
      wait_cycles(COUNT + HALF);
      check_drained("gapfill");
      check_fc("gapfill", 8'd1);
      drive(COUNT, t);
      wait_cycles(COUNT + HALF + 4);
      check_drained("gapfill2");
      check_fc("gapfill2", 8'd2);
   endtask

   task automatic test_gap_calc();
      int t;
      do_reset("gapcalc");
      drive(20, t);
      wait_cycles(COUNT + HALF);
      check_drained("gapcalc");
      check_fc("gapcalc", 8'd0);
   endtask

   task automatic test_reset_mid_drain();
      int t;
      do_reset("middrain_pre");
      drive(COUNT, t);
      wait_cycles(5);
      do_reset("middrain");
      wait_cycles(HALF + 4);
      check_drained("middrain");
      check_fc("middrain", 8'd0);
      drive(COUNT, t);
      wait_cycles(COUNT + HALF + 4);
      check_drained("middrain_next");
      check_fc("middrain_next", 8'd1);
   endtask

   task automatic test_wrap();
      int t;
      do_reset("wrap");
      drive(256 * COUNT, t);
      wait_cycles(COUNT + HALF + 4);
      check_drained("wrap");
      check_fc("wrap", 8'd0);
   endtask

   initial begin
      #2;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_gap_fill_drain();
      test_gap_calc();
      test_reset_mid_drain();
      test_wrap();
      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
